// File: rtl/maverickOne_pkg.sv
// Shared core definitions: architectural register count and the lock scheduler state encoding.
package maverickOne_pkg;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    BLOCKED = 2'd2
  } reg_lock_state_e;

endpackage

// File: rtl/reg_lock_sched_if.sv
// Issue / writeback / status bundle between decode and the register lock scheduler.
// stall_cnt_o is present only when REG_LOCK_SCHED_STATS_EN is defined.
interface reg_lock_sched_if #(
  parameter int NR  = maverickOne_pkg::NUM_REGS,
  parameter int NWB = 2
) ();

  localparam int IW = $clog2(NR);

  logic                    issue_valid_i;
  logic                    issue_ready_o;
  logic                    blocking_i;
  logic [IW-1:0]           rd_i;
  logic [NR-1:0]           reg_req_i;
  logic                    mem_op_i;
  logic [NWB-1:0]          wb_valid_i;
  logic [NWB-1:0][IW-1:0]  wb_rd_i;
  logic                    mem_done_i;
  logic                    block_done_i;
  logic [NR-1:0]           locks_o;
  logic                    mem_busy_o;
`ifdef REG_LOCK_SCHED_STATS_EN
  logic [31:0]             stall_cnt_o;
`endif

  modport master (
    output issue_valid_i, blocking_i, rd_i, reg_req_i, mem_op_i,
    output wb_valid_i, wb_rd_i, mem_done_i, block_done_i,
`ifdef REG_LOCK_SCHED_STATS_EN
    input  stall_cnt_o,
`endif
    input  issue_ready_o, locks_o, mem_busy_o
  );

  modport slave (
    input  issue_valid_i, blocking_i, rd_i, reg_req_i, mem_op_i,
    input  wb_valid_i, wb_rd_i, mem_done_i, block_done_i,
`ifdef REG_LOCK_SCHED_STATS_EN
    output stall_cnt_o,
`endif
    output issue_ready_o, locks_o, mem_busy_o
  );

endinterface

// File: rtl/reg_gnt_ckr.sv
// Issue readiness check and lock/memory set requests, evaluated against registered lock state only.
module reg_gnt_ckr
  import maverickOne_pkg::*;
#(
  parameter int NR = NUM_REGS,
  parameter int IW = $clog2(NR)
) (
  input  reg_lock_state_e cur_state,
  input  logic [NR-1:0]   locks,
  input  logic            mem_busy,
  input  logic            enable,
  input  logic            issue_valid,
  input  logic            blocking,
  input  logic [IW-1:0]   rd,
  input  logic [NR-1:0]   reg_req,
  input  logic            mem_op,
  output logic            ready,
  output logic            handshake,
  output logic [NR-1:0]   lock_set,
  output logic            mem_set
);

  logic all_clear_s;
  logic ok_s;

  assign all_clear_s = (locks == {NR{1'b0}}) && !mem_busy;

  // Readiness per state, then handshake-driven set requests
  always_comb begin
    ok_s      = 1'b0;
    ready     = 1'b0;
    handshake = 1'b0;
    lock_set  = {NR{1'b0}};
    mem_set   = 1'b0;
    case (cur_state)
      RUN: begin
        if (blocking) begin
          ok_s = all_clear_s;
        end else begin
          ok_s = ((reg_req & locks) == {NR{1'b0}}) && !(mem_op && mem_busy);
        end
      end
      DRAIN:   ok_s = all_clear_s;
      BLOCKED: ok_s = 1'b0;
      default: ok_s = 1'b0;
    endcase
    ready     = enable && ok_s;
    handshake = issue_valid && ready;
    // Register 0 is hard-wired and never tracked
    if (handshake && !blocking && (cur_state == RUN) && (rd != {IW{1'b0}})) begin
      lock_set[rd] = 1'b1;
    end else begin
      lock_set = {NR{1'b0}};
    end
    mem_set = handshake && mem_op;
  end

endmodule

// File: rtl/reg_lock_sched.sv
// Register lock scheduler: owns lock/memory-busy flops, the RUN/DRAIN/BLOCKED FSM and writeback clears.
// Optional stall counter output enabled by REG_LOCK_SCHED_STATS_EN.
module reg_lock_sched
  import maverickOne_pkg::*;
#(
  parameter int NR  = maverickOne_pkg::NUM_REGS,
  parameter int NWB = 2
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  reg_lock_sched_if.slave bus
);

  localparam int IW = $clog2(NR);

  reg_lock_state_e state_r, state_s;
  logic [NR-1:0]   locks_r, locks_s;
  logic [NR-1:0]   set_mask_s, wb_clr_s;
  logic            mem_busy_r, mem_busy_s;
  logic            ready_s, hs_s, mem_set_s;

  reg_gnt_ckr #(.NR(NR), .IW(IW)) u_gnt_ckr (
    .cur_state   (state_r),
    .locks       (locks_r),
    .mem_busy    (mem_busy_r),
    .enable      (arst_ni),
    .issue_valid (bus.issue_valid_i),
    .blocking    (bus.blocking_i),
    .rd          (bus.rd_i),
    .reg_req     (bus.reg_req_i),
    .mem_op      (bus.mem_op_i),
    .ready       (ready_s),
    .handshake   (hs_s),
    .lock_set    (set_mask_s),
    .mem_set     (mem_set_s)
  );

  // Writeback clear mask; bit 0 is never a valid target
  always_comb begin
    wb_clr_s = {NR{1'b0}};
    for (int k = 0; k < NWB; k++) begin
      wb_clr_s[bus.wb_rd_i[k]] = wb_clr_s[bus.wb_rd_i[k]] | bus.wb_valid_i[k];
    end
    wb_clr_s[0] = 1'b0;
  end

  // Next state, next locks and next memory-busy flag
  always_comb begin
    state_s    = state_r;
    locks_s    = locks_r;
    mem_busy_s = mem_busy_r;
    case (state_r)
      RUN, DRAIN: begin
        // OR-ing the set after the clear makes a same-cycle issue win
        locks_s = (locks_r & ~wb_clr_s) | set_mask_s;
        if (hs_s && (bus.blocking_i || (state_r == DRAIN))) begin
          state_s = BLOCKED;
          locks_s = {NR{1'b1}};
        end else if (bus.issue_valid_i && bus.blocking_i) begin
          state_s = DRAIN;
        end else begin
          state_s = state_r;
        end
      end
      BLOCKED: begin
        if (bus.block_done_i) begin
          state_s = RUN;
          locks_s = {NR{1'b0}};
        end else begin
          state_s = BLOCKED;
          locks_s = locks_r;
        end
      end
      default: begin
        state_s = RUN;
        locks_s = {NR{1'b0}};
      end
    endcase
    if (mem_set_s) begin
      mem_busy_s = 1'b1;
    end else if (bus.mem_done_i) begin
      mem_busy_s = 1'b0;
    end else begin
      mem_busy_s = mem_busy_r;
    end
  end

  // State, lock and busy registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_r    <= RUN;
      locks_r    <= {NR{1'b0}};
      mem_busy_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      locks_r    <= locks_s;
      mem_busy_r <= mem_busy_s;
    end
  end

  assign bus.issue_ready_o = ready_s;
  assign bus.locks_o       = locks_r;
  assign bus.mem_busy_o    = mem_busy_r;

`ifdef REG_LOCK_SCHED_STATS_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of offered-but-not-accepted cycles
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stall_cnt_r <= 32'd0;
    end else if (bus.issue_valid_i && !ready_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_reg_lock_sched.sv
// Table-driven bench for reg_lock_sched with a scoreboard queue of post-edge expectations.
module tb_reg_lock_sched;

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_BLOCKED = 2'd2;
  localparam int         NV        = 24;

  typedef struct {
    logic        v, b;
    logic [4:0]  rd;
    logic [31:0] req;
    logic        mem;
    logic [1:0]  wbv;
    logic [4:0]  wr0, wr1;
    logic        md, bd;
    logic        rdy;
    logic [31:0] locks;
    logic        busy;
    logic [1:0]  st;
  } vec_t;

  typedef struct {
    logic [31:0] locks;
    logic        busy;
    logic [1:0]  st;
  } exp_t;

  logic clk_i;
  logic arst_ni;
  int   errors;
  int   checks;
  vec_t tbl [NV];
  exp_t sbq [$];

  reg_lock_sched_if #(.NR(32), .NWB(2)) bus ();

  reg_lock_sched #(.NR(32), .NWB(2)) dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic v, input logic b, input logic [4:0] rd,
                              input logic [31:0] req, input logic mem, input logic [1:0] wbv,
                              input logic [4:0] wr0, input logic [4:0] wr1, input logic md,
                              input logic bd, input logic rdy, input logic [31:0] lk,
                              input logic busy, input logic [1:0] st);
    vec_t r;
    r.v = v; r.b = b; r.rd = rd; r.req = req; r.mem = mem; r.wbv = wbv;
    r.wr0 = wr0; r.wr1 = wr1; r.md = md; r.bd = bd;
    r.rdy = rdy; r.locks = lk; r.busy = busy; r.st = st;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic [4:0] rd, input logic [31:0] req,
                       input logic mem, input logic [1:0] wbv, input logic [4:0] wr0,
                       input logic [4:0] wr1, input logic md, input logic bd);
    bus.issue_valid_i = v;
    bus.blocking_i    = b;
    bus.rd_i          = rd;
    bus.reg_req_i     = req;
    bus.mem_op_i      = mem;
    bus.wb_valid_i    = wbv;
    bus.wb_rd_i[0]    = wr0;
    bus.wb_rd_i[1]    = wr1;
    bus.mem_done_i    = md;
    bus.block_done_i  = bd;
  endtask

  task automatic check_post(input string tag);
    exp_t        e;
    logic [1:0]  st_a;
    e    = sbq.pop_front();
    st_a = 2'(dut.state_r);
    check({tag, " locks"}, bus.locks_o, e.locks);
    check({tag, " mem_busy"}, {31'd0, bus.mem_busy_o}, {31'd0, e.busy});
    check({tag, " state"}, {30'd0, st_a}, {30'd0, e.st});
  endtask

  // Called at posedge+1: ready sampled at the negedge, registered outputs at the next posedge+1
  task automatic apply(input int i);
    exp_t  e;
    string tag;
    tag = $sformatf("vec%0d", i);
    drive(tbl[i].v, tbl[i].b, tbl[i].rd, tbl[i].req, tbl[i].mem,
          tbl[i].wbv, tbl[i].wr0, tbl[i].wr1, tbl[i].md, tbl[i].bd);
    @(negedge clk_i);
    if (tbl[i].v) begin
      check({tag, " ready"}, {31'd0, bus.issue_ready_o}, {31'd0, tbl[i].rdy});
    end
    e.locks = tbl[i].locks;
    e.busy  = tbl[i].busy;
    e.st    = tbl[i].st;
    sbq.push_back(e);
    @(posedge clk_i);
    #1;
    check_post(tag);
  endtask

  initial begin
    exp_t e;
    errors = 0;
    checks = 0;

    //            v     b     rd     req           mem   wbv    wr0    wr1    md    bd    rdy   locks          busy  state
    tbl[0]  = mk(1'b1, 1'b0, 5'd5,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h20,        1'b0, S_RUN);
    tbl[1]  = mk(1'b1, 1'b0, 5'd7,  32'h20,       1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h20,        1'b0, S_RUN);
    tbl[2]  = mk(1'b1, 1'b0, 5'd7,  32'h20,       1'b0, 2'b01, 5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, S_RUN);
    tbl[3]  = mk(1'b1, 1'b0, 5'd7,  32'h20,       1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h80,        1'b0, S_RUN);
    tbl[4]  = mk(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h80,        1'b0, S_RUN);
    tbl[5]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 2'b01, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h80,        1'b0, S_RUN);
    tbl[6]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 2'b10, 5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, S_RUN);
    tbl[7]  = mk(1'b1, 1'b0, 5'd3,  32'h0,        1'b0, 2'b01, 5'd3,  5'd0,  1'b0, 1'b0, 1'b1, 32'h8,         1'b0, S_RUN);
    tbl[8]  = mk(1'b1, 1'b1, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h8,         1'b0, S_DRAIN);
    tbl[9]  = mk(1'b1, 1'b1, 5'd0,  32'h0,        1'b0, 2'b10, 5'd0,  5'd3,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, S_DRAIN);
    tbl[10] = mk(1'b1, 1'b1, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, S_BLOCKED);
    tbl[11] = mk(1'b1, 1'b0, 5'd2,  32'h0,        1'b0, 2'b01, 5'd4,  5'd0,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, S_BLOCKED);
    tbl[12] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, S_RUN);
    tbl[13] = mk(1'b1, 1'b0, 5'd9,  32'h0,        1'b1, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h200,       1'b1, S_RUN);
    tbl[14] = mk(1'b1, 1'b0, 5'd10, 32'h0,        1'b1, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h200,       1'b1, S_RUN);
    tbl[15] = mk(1'b1, 1'b0, 5'd10, 32'h0,        1'b1, 2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 32'h200,       1'b0, S_RUN);
    tbl[16] = mk(1'b1, 1'b0, 5'd10, 32'h0,        1'b1, 2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 32'h600,       1'b1, S_RUN);
    tbl[17] = mk(1'b1, 1'b0, 5'd11, 32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hE00,       1'b1, S_RUN);
    tbl[18] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 32'hE00,       1'b0, S_RUN);
    tbl[19] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 2'b11, 5'd9,  5'd10, 1'b0, 1'b0, 1'b0, 32'h800,       1'b0, S_RUN);
    tbl[20] = mk(1'b1, 1'b0, 5'd0,  32'h800,      1'b0, 2'b01, 5'd11, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, S_RUN);
    tbl[21] = mk(1'b1, 1'b1, 5'd0,  32'h0,        1'b1, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, S_BLOCKED);
    tbl[22] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 32'h0,         1'b0, S_RUN);
    tbl[23] = mk(1'b1, 1'b1, 5'd0,  32'h0,        1'b0, 2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, S_BLOCKED);

    // Reset with an otherwise-acceptable offer on the bus
    arst_ni = 1'b0;
    drive(1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("reset ready", {31'd0, bus.issue_ready_o}, 32'd0);
    check("reset locks", bus.locks_o, 32'h0);
    check("reset mem_busy", {31'd0, bus.mem_busy_o}, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("reset held locks", bus.locks_o, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    arst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(i);
    end

    // Asynchronous reset in the middle of BLOCKED
    drive(1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    check("pre-reset locks", bus.locks_o, 32'hFFFF_FFFF);
    arst_ni = 1'b0;
    #1;
    check("midrst locks", bus.locks_o, 32'h0);
    check("midrst mem_busy", {31'd0, bus.mem_busy_o}, 32'd0);
    check("midrst state", {30'd0, 2'(dut.state_r)}, {30'd0, S_RUN});
    check("midrst ready", {31'd0, bus.issue_ready_o}, 32'd0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    #1;
    check("postrst ready", {31'd0, bus.issue_ready_o}, 32'd1);
    e.locks = 32'h2;
    e.busy  = 1'b0;
    e.st    = S_RUN;
    sbq.push_back(e);
    @(posedge clk_i);
    #1;
    check_post("postrst");
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_lock_sched.md
REG_LOCK_SCHED -- requirements
Module: reg_lock_sched

Interface
REQ-001 SHALL have parameter NR, default maverickOne_pkg::NUM_REGS, number of architectural registers.
REQ-002 SHALL have parameter NWB, default 2, number of writeback ports.
REQ-003 SHALL have port clk_i  input  1  the single clock for all state.
REQ-004 SHALL have port arst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port issue_valid_i  input  1  decode offers an instruction.
REQ-006 SHALL have port issue_ready_o  output  1  the scheduler accepts the offered instruction.
REQ-007 SHALL have port blocking_i  input  1  the offered instruction is blocking.
REQ-008 SHALL have port rd_i  input  $clog2(NR)  destination register index.
REQ-009 SHALL have port reg_req_i  input  NR  bitmask of required source registers.
REQ-010 SHALL have port mem_op_i  input  1  the offered instruction is a memory operation.
REQ-011 SHALL have port wb_valid_i  input  NWB  writeback strobe per port.
REQ-012 SHALL have port wb_rd_i  input  NWB x $clog2(NR)  writeback register index per port.
REQ-013 SHALL have port mem_done_i  input  1  the outstanding memory operation has completed.
REQ-014 SHALL have port block_done_i  input  1  the in-flight blocking instruction has retired.
REQ-015 SHALL have port locks_o  output  NR  registered lock bitmask.
REQ-016 SHALL have port mem_busy_o  output  1  registered flag: a memory operation is outstanding.

Function
REQ-017 SHALL implement a state machine with states RUN, DRAIN and BLOCKED; an issue handshake SHALL occur when issue_valid_i and issue_ready_o are both 1.
REQ-018 In RUN with blocking_i=0, issue_ready_o SHALL be 1 only when no bit of reg_req_i is set in locks_o and mem_op_i AND mem_busy_o is 0; the decision uses registered state only.
REQ-019 On a non-blocking handshake, locks_o[rd_i] SHALL set on the next edge unless rd_i=0; bit 0 SHALL never be set outside BLOCKED.
REQ-020 In RUN, issue_valid_i=1 with blocking_i=1 SHALL hold issue_ready_o at 0 and move the FSM to DRAIN, unless locks_o is all-zero and mem_busy_o=0, in which case issue_ready_o SHALL be 1 in RUN.
REQ-021 In DRAIN, issue_ready_o SHALL be 1 only when locks_o is all-zero and mem_busy_o=0; a handshake SHALL move the FSM to BLOCKED.
REQ-022 Entering BLOCKED SHALL set locks_o to all-ones; in BLOCKED issue_ready_o SHALL be 0 and writebacks SHALL be ignored.
REQ-023 In BLOCKED, block_done_i SHALL clear locks_o to zero and return the FSM to RUN on the next edge.
REQ-024 Each valid writeback SHALL clear locks_o[wb_rd_i[k]] on the next edge; an index of 0 SHALL have no effect.
REQ-025 When a writeback clear and an issue set hit the same register in one cycle, the set SHALL win.
REQ-026 mem_busy_o SHALL set on a handshake with mem_op_i=1 and clear on mem_done_i; when done and a new memory issue coincide, mem_busy_o SHALL stay 1.
REQ-027 Issue-to-lock latency SHALL be 1 cycle, and writeback-to-unlock latency SHALL be 1 cycle.

Reset
REQ-028 Asserting arst_ni low SHALL immediately force FSM=RUN, locks_o=0 and mem_busy_o=0, including mid-DRAIN or mid-BLOCKED.
REQ-029 issue_ready_o SHALL be 0 while arst_ni is low.

Configuration
REQ-030 With REG_LOCK_SCHED_STATS_EN defined, the block SHALL add an output stall_cnt_o (32 bits) that counts cycles where issue_valid_i=1 and issue_ready_o=0, saturates at all-ones, and resets to 0.
REQ-031 Without REG_LOCK_SCHED_STATS_EN, the stall_cnt_o port and its counter SHALL be absent.

Structure
REQ-032 The state enum type reg_lock_state_e SHALL be declared in maverickOne_pkg, which already provides NUM_REGS.
REQ-033 The readiness and lock-update logic SHALL be a reg_gnt_ckr instance operating on the registered locks_o and mem_busy_o; this block owns the flops, the FSM and the writeback clears.

Verification
REQ-034 Reset, then issue rd=5 with no sources -> ready=1; the cycle after, locks_o=0x20.
REQ-035 locks_o[5]=1, issue with reg_req=0x20 -> ready=0; wb_valid[0]=1 with wb_rd=5 -> ready=1 in the following cycle.
REQ-036 Issue rd=0 -> locks_o unchanged; wb_rd=0 -> no effect.
REQ-037 locks_o=0x8 and a blocking issue -> DRAIN with ready=0; wb clears reg 3 -> ready=1; after the handshake, locks_o=all-ones; block_done_i -> locks_o=0 and FSM=RUN.
REQ-038 Memory issue -> mem_busy_o=1 and a second memory issue is stalled; mem_done_i together with a new memory issue -> mem_busy_o stays 1.
REQ-039 Assert arst_ni low while in BLOCKED -> locks_o=0 and mem_busy_o=0 immediately, FSM=RUN.
